// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings and access-mask constants for the memory arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
    typedef enum logic {OWN_IMEM, OWN_DMEM} owner_e;
    localparam logic [2:0] MASK_B  = 3'b000;
    localparam logic [2:0] MASK_H  = 3'b001;
    localparam logic [2:0] MASK_W  = 3'b010;
    localparam logic [2:0] MASK_BU = 3'b100;
    localparam logic [2:0] MASK_HU = 3'b101;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and memory-side signals of the arbiter; slave is the arbiter's view.
interface mem_arbiter_if;
    logic        i_imem_req;
    logic [31:0] i_imem_addr;
    logic        o_imem_ready;
    logic        o_imem_valid;
    logic [31:0] o_imem_rdata;
    logic        i_dmem_req;
    logic [31:0] i_dmem_addr;
    logic        i_dmem_wen;
    logic [31:0] i_dmem_wdata;
    logic [2:0]  i_dmem_mask;
    logic        o_dmem_ready;
    logic        o_dmem_valid;
    logic [31:0] o_dmem_rdata;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic [2:0]  o_mem_mask;
    logic        i_mem_ready;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        o_timeout;
    modport slave (
        input  i_imem_req, i_imem_addr, i_dmem_req, i_dmem_addr, i_dmem_wen, i_dmem_wdata,
               i_dmem_mask, i_mem_ready, i_mem_rvalid, i_mem_rdata,
        output o_imem_ready, o_imem_valid, o_imem_rdata, o_dmem_ready, o_dmem_valid,
               o_dmem_rdata, o_mem_req, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_mask, o_timeout
    );
    modport master (
        output i_imem_req, i_imem_addr, i_dmem_req, i_dmem_addr, i_dmem_wen, i_dmem_wdata,
               i_dmem_mask, i_mem_ready, i_mem_rvalid, i_mem_rdata,
        input  o_imem_ready, o_imem_valid, o_imem_rdata, o_dmem_ready, o_dmem_valid,
               o_dmem_rdata, o_mem_req, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_mask, o_timeout
    );
endinterface

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: data-over-fetch priority, overridden for fetch once the data streak is exhausted.
module mem_arb_grant #(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic       imem_req_i,
    input  logic       dmem_req_i,
    input  logic [3:0] streak_i,
    output logic       grant_imem_o,
    output logic       grant_dmem_o
);
    logic force_imem;
    assign force_imem   = imem_req_i && dmem_req_i && streak_i == 4'(MAX_DATA_STREAK);
    assign grant_imem_o = imem_req_i && (!dmem_req_i || force_imem);
    assign grant_dmem_o = dmem_req_i && !force_imem;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-outstanding arbiter sharing one memory between fetch and data.
// Define MEM_ARB_TIMEOUT_EN to abort transactions after TIMEOUT_CYCLES in ISSUE+WAIT.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    mem_arbiter_if.slave  arb
);
    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic        wen_q, wen_d;
    logic [2:0]  mask_q, mask_d;
    logic [3:0]  streak_q, streak_d;
    logic        imem_valid_q, imem_valid_d, dmem_valid_q, dmem_valid_d;
    logic [31:0] imem_rdata_q, imem_rdata_d, dmem_rdata_q, dmem_rdata_d;
    logic        grant_imem, grant_dmem, idle, done, abort;
    logic [31:0] rd;

    mem_arb_grant #(.MAX_DATA_STREAK(MAX_DATA_STREAK)) u_grant (
        .imem_req_i   (arb.i_imem_req),
        .dmem_req_i   (arb.i_dmem_req),
        .streak_i     (streak_q),
        .grant_imem_o (grant_imem),
        .grant_dmem_o (grant_dmem)
    );

    assign idle = state_q == IDLE;
    assign done = state_q == WAIT && arb.i_mem_rvalid;
    assign rd   = (done && !wen_q) ? arb.i_mem_rdata : 32'd0;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
    assign abort     = !idle && (cnt_q + 16'd1 == 16'(TIMEOUT_CYCLES));
    assign cnt_d     = (idle || abort || done) ? 16'd0 : cnt_q + 16'd1;
    assign timeout_d = timeout_q | (abort & ~done);
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign arb.o_timeout = timeout_q;
`else
    assign abort         = 1'b0;
    assign arb.o_timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        mask_d       = mask_q;
        streak_d     = streak_q;
        imem_valid_d = 1'b0;
        dmem_valid_d = 1'b0;
        imem_rdata_d = imem_rdata_q;
        dmem_rdata_d = dmem_rdata_q;
        if (idle && (grant_imem || grant_dmem)) begin
            state_d  = ISSUE;
            owner_d  = grant_dmem ? OWN_DMEM : OWN_IMEM;
            addr_d   = grant_dmem ? arb.i_dmem_addr : arb.i_imem_addr;
            wen_d    = grant_dmem && arb.i_dmem_wen;
            wdata_d  = grant_dmem ? arb.i_dmem_wdata : 32'd0;
            mask_d   = grant_dmem ? arb.i_dmem_mask : MASK_W;
            streak_d = !(grant_dmem && arb.i_imem_req) ? 4'd0 :
                       streak_q == 4'(MAX_DATA_STREAK) ? streak_q : streak_q + 4'd1;
        end
        if (state_q == ISSUE && arb.i_mem_ready)
            state_d = WAIT;
        // A timeout completes the transaction like a response, but with zero data.
        if (done || abort) begin
            state_d      = IDLE;
            imem_valid_d = owner_q == OWN_IMEM;
            dmem_valid_d = owner_q == OWN_DMEM;
            imem_rdata_d = owner_q == OWN_IMEM ? rd : imem_rdata_q;
            dmem_rdata_d = owner_q == OWN_DMEM ? rd : dmem_rdata_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IMEM;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            mask_q       <= '0;
            streak_q     <= '0;
            imem_valid_q <= 1'b0;
            dmem_valid_q <= 1'b0;
            imem_rdata_q <= '0;
            dmem_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            mask_q       <= mask_d;
            streak_q     <= streak_d;
            imem_valid_q <= imem_valid_d;
            dmem_valid_q <= dmem_valid_d;
            imem_rdata_q <= imem_rdata_d;
            dmem_rdata_q <= dmem_rdata_d;
        end
    end

    assign arb.o_imem_ready = i_rst_n && idle && grant_imem;
    assign arb.o_dmem_ready = i_rst_n && idle && grant_dmem;
    assign arb.o_imem_valid = imem_valid_q;
    assign arb.o_dmem_valid = dmem_valid_q;
    assign arb.o_imem_rdata = imem_rdata_q;
    assign arb.o_dmem_rdata = dmem_rdata_q;
    assign arb.o_mem_req    = state_q == ISSUE;
    assign arb.o_mem_addr   = addr_q;
    assign arb.o_mem_wen    = wen_q;
    assign arb.o_mem_wdata  = wdata_q;
    assign arb.o_mem_mask   = mask_q;
endmodule
